uart_rx_dir: RTL and testbench

- Serial receiver at the far end of the UART link driven by the team's uart_tx block.
- Deserialises 8N1 frames: idle high, one start bit, 8 data bits LSB first, one stop bit.
- Presents each received byte with a one-cycle valid strobe.
- Optionally decodes WASD key bytes into the snake game's 3-bit direction code, which is consumed by the game control logic.

---
 rtl/uart_rx_dir_if.sv | 19 +
 rtl/uart_rx_dir.sv | 150 +++++++++++++++
 tb/tb_uart_rx_dir.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_dir_if.sv
// Signal bundle between the UART serial line, the receiver and the game logic reading its bytes.
interface uart_rx_dir_if;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;
    logic [2:0] direction;

    modport master (
        output uart_rxd,
        input  rx_data, rx_valid, frame_err, rx_busy, direction
    );

    modport slave (
        input  uart_rxd,
        output rx_data, rx_valid, frame_err, rx_busy, direction
    );
endinterface

// File: rtl/uart_rx_dir.sv
// 8N1 UART receiver with one-cycle valid/frame-error strobes and optional WASD decode
// into the snake game direction code (enable with macro UART_RX_DIR_DECODE_EN).
module uart_rx_dir #(
    parameter int SYS_CLK_FRE = 50_000_000,
    parameter int BPS         = 9_600
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    uart_rx_dir_if.slave rx_if
);
    localparam int          BPS_CNT   = SYS_CLK_FRE / BPS;
    localparam logic [15:0] BIT_LAST  = 16'(BPS_CNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(BPS_CNT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic        rxd_s1, rxd_s2, rxd_s3;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        frame_err_r;
    logic        rx_busy_r;
    logic        start_edge;
    logic        bit_mid;

    assign start_edge = rxd_s3 && !rxd_s2;
    assign bit_mid    = (clk_cnt == BIT_LAST);

    // Two flops tame metastability; the third only exists to spot the falling edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= rx_if.uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            rx_busy_r   <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (start_edge) begin
                        state     <= START;
                        rx_busy_r <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (rxd_s2) begin
                            state     <= IDLE;
                            rx_busy_r <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_mid) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rxd_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a start bit immediately following is not missed.
                    if (bit_mid) begin
                        clk_cnt   <= '0;
                        state     <= IDLE;
                        rx_busy_r <= 1'b0;
                        if (rxd_s2) begin
                            rx_data_r  <= shift_reg;
                            rx_valid_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rx_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.rx_data   = rx_data_r;
    assign rx_if.rx_valid  = rx_valid_r;
    assign rx_if.frame_err = frame_err_r;
    assign rx_if.rx_busy   = rx_busy_r;

`ifdef UART_RX_DIR_DECODE_EN
    logic [2:0] direction_r;
    logic [2:0] key_code;

    always_comb begin
        key_code = 3'd0;
        case (shift_reg)
            8'h57, 8'h77: key_code = 3'd1;
            8'h53, 8'h73: key_code = 3'd2;
            8'h41, 8'h61: key_code = 3'd3;
            8'h44, 8'h64: key_code = 3'd4;
            default:      key_code = 3'd0;
        endcase
    end

    // Updates on the same edge that raises rx_valid; non-key bytes keep the last heading.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            direction_r <= 3'd0;
        end else if ((state == STOP) && bit_mid && rxd_s2 && (key_code != 3'd0)) begin
            direction_r <= key_code;
        end
    end

    assign rx_if.direction = direction_r;
`else
    assign rx_if.direction = 3'd0;
`endif
endmodule

// File: tb/tb_uart_rx_dir.sv
// Randomised and directed bench for uart_rx_dir, checked every cycle against a frame-level
// model (expected-frame queue, last good byte, key decode). Honours UART_RX_DIR_DECODE_EN.
module tb_uart_rx_dir;
    localparam int BPS_CNT = 10;
    localparam int LAT     = 3 + BPS_CNT / 2 + 9 * BPS_CNT;

    typedef struct packed {
        logic [7:0] data;
        logic       good;
        int         start_cyc;
    } frame_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc       = 0;

    uart_rx_dir_if rx_if ();

    uart_rx_dir #(
        .SYS_CLK_FRE(1_000_000),
        .BPS        (100_000)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .rx_if    (rx_if)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    frame_t     exp_q[$];
    frame_t     f;
    logic [7:0] model_data = 8'd0;
    logic [2:0] model_dir  = 3'd0;
    int         n_checks   = 0;
    int         n_fail     = 0;
    bit         prev_pulse = 1'b0;
    int         lat;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] keyToDir(input logic [7:0] b);
        logic [2:0] d;
        d = 3'd0;
`ifdef UART_RX_DIR_DECODE_EN
        case (b & 8'hDF)
            "W":     d = 3'd1;
            "S":     d = 3'd2;
            "A":     d = 3'd3;
            "D":     d = 3'd4;
            default: d = 3'd0;
        endcase
`endif
        return d;
    endfunction

    // Compare process: pulses are matched against queued frames, levels against the model.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                exp_q.delete();
                model_data = 8'd0;
                model_dir  = 3'd0;
                prev_pulse = 1'b0;
                checkOutput("reset_rx_data", rx_if.rx_data, 0);
                checkOutput("reset_rx_valid", rx_if.rx_valid, 0);
                checkOutput("reset_frame_err", rx_if.frame_err, 0);
                checkOutput("reset_rx_busy", rx_if.rx_busy, 0);
                checkOutput("reset_direction", rx_if.direction, 0);
            end else begin
                if (exp_q.size() > 0 && (cyc - exp_q[0].start_cyc) > LAT + 2) begin
                    f = exp_q.pop_front();
                    checkOutput("missing_pulse_for_byte", 0, {24'd0, f.data});
                end
                if (rx_if.rx_valid || rx_if.frame_err) begin
                    checkOutput("valid_err_exclusive", rx_if.rx_valid & rx_if.frame_err, 0);
                    checkOutput("pulse_width", prev_pulse, 0);
                    checkOutput("busy_low_at_pulse", rx_if.rx_busy, 0);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_pulse", 1, 0);
                    end else begin
                        f   = exp_q.pop_front();
                        lat = cyc - f.start_cyc;
                        checkOutput("pulse_is_valid", rx_if.rx_valid, f.good);
                        checkOutput("latency", (lat >= LAT - 2 && lat <= LAT + 2) ? LAT : lat, LAT);
                        if (f.good) begin
                            model_data = f.data;
                            if (keyToDir(f.data) != 3'd0) model_dir = keyToDir(f.data);
                        end
                    end
                end
                checkOutput("rx_data", rx_if.rx_data, model_data);
                checkOutput("direction", rx_if.direction, model_dir);
                if (exp_q.size() > 0 && (cyc - exp_q[0].start_cyc) >= 10
                    && (cyc - exp_q[0].start_cyc) <= 90) begin
                    checkOutput("busy_mid_frame", rx_if.rx_busy, 1);
                end
                prev_pulse = rx_if.rx_valid || rx_if.frame_err;
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic driveBit(input logic b);
        rx_if.uart_rxd = b;
        waitCycles(BPS_CNT);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int gap);
        exp_q.push_back('{data: data, good: stop_bit, start_cyc: cyc});
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(stop_bit);
        rx_if.uart_rxd = 1'b1;
        waitCycles(gap);
    endtask

    logic [7:0] keys[8] = '{8'h57, 8'h77, 8'h53, 8'h73, 8'h41, 8'h61, 8'h44, 8'h64};

    initial begin
        logic [7:0] b;
        rx_if.uart_rxd = 1'b1;
        waitCycles(4);
        sys_rst_n = 1'b1;
        waitCycles(5);

        $display("[TB] single byte 0xA5");
        applyStimulus(8'hA5, 1'b1, 5);
        checkOutput("t1_rx_data", rx_if.rx_data, 8'hA5);
        checkOutput("t1_busy_idle", rx_if.rx_busy, 0);

        $display("[TB] back-to-back 0x77, 0x64");
        applyStimulus(8'h77, 1'b1, 0);
        applyStimulus(8'h64, 1'b1, 5);
        checkOutput("t2_rx_data", rx_if.rx_data, 8'h64);
`ifdef UART_RX_DIR_DECODE_EN
        checkOutput("t2_direction", rx_if.direction, 4);
`else
        checkOutput("t2_direction", rx_if.direction, 0);
`endif

        $display("[TB] 3-cycle glitch then 0x3C");
        rx_if.uart_rxd = 1'b0;
        waitCycles(3);
        rx_if.uart_rxd = 1'b1;
        waitCycles(20);
        checkOutput("t3_busy_after_glitch", rx_if.rx_busy, 0);
        applyStimulus(8'h3C, 1'b1, 5);
        checkOutput("t3_rx_data", rx_if.rx_data, 8'h3C);

        $display("[TB] 0x55 with stop bit low");
        applyStimulus(8'h55, 1'b0, 5);
        checkOutput("t4_rx_data_held", rx_if.rx_data, 8'h3C);
`ifdef UART_RX_DIR_DECODE_EN
        checkOutput("t4_direction_held", rx_if.direction, 4);
`else
        checkOutput("t4_direction_held", rx_if.direction, 0);
`endif

        $display("[TB] reset during data bit 4 of 0xFF, then 0x12");
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b1);
        rx_if.uart_rxd = 1'b1;
        waitCycles(3);
        sys_rst_n = 1'b0;
        waitCycles(5);
        sys_rst_n = 1'b1;
        waitCycles(2);
        for (int i = 0; i < 4; i++) driveBit(1'b1);
        waitCycles(10);
        checkOutput("t5_busy_after_reset", rx_if.rx_busy, 0);
        applyStimulus(8'h12, 1'b1, 5);
        checkOutput("t5_rx_data", rx_if.rx_data, 8'h12);
        checkOutput("t5_direction", rx_if.direction, 0);

        $display("[TB] 0x41 then 0x20");
        applyStimulus(8'h41, 1'b1, 3);
`ifdef UART_RX_DIR_DECODE_EN
        checkOutput("t6_direction_a", rx_if.direction, 3);
`else
        checkOutput("t6_direction_a", rx_if.direction, 0);
`endif
        applyStimulus(8'h20, 1'b1, 5);
        checkOutput("t6_rx_data", rx_if.rx_data, 8'h20);
`ifdef UART_RX_DIR_DECODE_EN
        checkOutput("t6_direction_kept", rx_if.direction, 3);
`else
        checkOutput("t6_direction_kept", rx_if.direction, 0);
`endif

        $display("[TB] break condition");
        exp_q.push_back('{data: 8'h00, good: 1'b0, start_cyc: cyc});
        rx_if.uart_rxd = 1'b0;
        waitCycles(40 * BPS_CNT);
        rx_if.uart_rxd = 1'b1;
        waitCycles(30);
        checkOutput("break_rx_data_held", rx_if.rx_data, 8'h20);

        $display("[TB] randomised frames");
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 0) b = keys[$urandom_range(0, 7)];
            else                           b = 8'($urandom_range(0, 255));
            applyStimulus(b, ($urandom_range(0, 7) != 0), $urandom_range(0, 12));
        end

        for (int t = 0; t < 300 && exp_q.size() > 0; t++) @(posedge sys_clk);
        waitCycles(2);
        checkOutput("frames_outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
